prod_burst_reducer: RTL and testbench

Downstream consumer of the multiplier's block-read stream. On request it pulses EN_blockRead and accepts a burst of BURST_LEN products on memVal_data/VALID_memVal. It reduces the burst to a full-precision sum, an unsigned maximum and a beat count, then holds the result under a valid/enable handshake until the consumer takes it.

---
 rtl/prod_burst_reducer.sv | 126 ++++++++++++
 tb/tb_prod_burst_reducer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/prod_burst_reducer.sv
// Burst reducer: requests one block read, folds BURST_LEN products into sum/max/count,
// and holds the result until taken. Optional idle timeout via `REDUCER_TIMEOUT_EN.
module prod_burst_reducer #(
    parameter int WIDTH          = 32,
    parameter int BURST_LEN      = 64,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int SW            = WIDTH + $clog2(BURST_LEN),
    localparam int CW            = $clog2(BURST_LEN) + 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN_start,
    output logic             RDY_start,
    output logic             EN_blockRead,
    input  logic             VALID_memVal,
    input  logic [WIDTH-1:0] memVal_data,
    output logic             VALID_result,
    input  logic             EN_result,
    output logic [SW-1:0]    result_sum,
    output logic [WIDTH-1:0] result_max,
    output logic [CW-1:0]    result_beats,
    output logic             result_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        COLLECT,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [SW-1:0]    sum_q;
    logic [WIDTH-1:0] max_q;
    logic [CW-1:0]    beats_q;
    logic             accept;
    logic             last_beat;
    logic             timeout;
    logic             start;

    assign start     = (state_q == IDLE) && EN_start;
    assign accept    = VALID_memVal && ((state_q == REQ) || (state_q == COLLECT));
    assign last_beat = accept && (beats_q == CW'(BURST_LEN - 1));

`ifdef REDUCER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_q;
    logic          err_q;

    // A beat in the limit cycle wins, so only a non-valid cycle can time out.
    assign timeout = (state_q == COLLECT) && !VALID_memVal &&
                     (idle_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idle_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q != COLLECT || accept) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + TW'(1);
            end

            if (start) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign result_err = err_q;
`else
    assign timeout    = 1'b0;
    assign result_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (EN_start) state_d = REQ;
            REQ:     state_d = last_beat ? DONE : COLLECT;
            COLLECT: if (last_beat || timeout) state_d = DONE;
            DONE:    if (EN_result) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sum_q   <= '0;
            max_q   <= '0;
            beats_q <= '0;
        end else if (start) begin
            sum_q   <= '0;
            max_q   <= '0;
            beats_q <= '0;
        end else if (accept) begin
            sum_q   <= sum_q + SW'(memVal_data);
            if (memVal_data > max_q) max_q <= memVal_data;
            beats_q <= beats_q + CW'(1);
        end
    end

    // Outputs are state decodes or registers only; nothing passes straight from inputs.
    assign RDY_start    = (state_q == IDLE);
    assign EN_blockRead = (state_q == REQ);
    assign VALID_result = (state_q == DONE);
    assign result_sum   = sum_q;
    assign result_max   = max_q;
    assign result_beats = beats_q;

endmodule

// File: tb/tb_prod_burst_reducer.sv
// Directed self-checking bench for prod_burst_reducer (default parameters).
// Timeout scenario follows `REDUCER_TIMEOUT_EN when the same define is given to the bench.
module tb_prod_burst_reducer;

    localparam int WIDTH = 32;
    localparam int SW    = 38;
    localparam int CW    = 7;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             EN_start = 1'b0;
    logic             RDY_start;
    logic             EN_blockRead;
    logic             VALID_memVal = 1'b0;
    logic [WIDTH-1:0] memVal_data = '0;
    logic             VALID_result;
    logic             EN_result = 1'b0;
    logic [SW-1:0]    result_sum;
    logic [WIDTH-1:0] result_max;
    logic [CW-1:0]    result_beats;
    logic             result_err;

    int total = 0;
    int bad   = 0;
    int pulses;

    prod_burst_reducer dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .EN_start     (EN_start),
        .RDY_start    (RDY_start),
        .EN_blockRead (EN_blockRead),
        .VALID_memVal (VALID_memVal),
        .memVal_data  (memVal_data),
        .VALID_result (VALID_result),
        .EN_result    (EN_result),
        .result_sum   (result_sum),
        .result_max   (result_max),
        .result_beats (result_beats),
        .result_err   (result_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns so outputs are sampled away from the edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_burst();
        EN_start = 1'b1;
        cyc();
        EN_start = 1'b0;
    endtask

    task automatic take_result();
        EN_result = 1'b1;
        cyc();
        EN_result = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_rdy", 64'(RDY_start), 64'd1);
        check("rst_blockread", 64'(EN_blockRead), 64'd0);
        check("rst_valid", 64'(VALID_result), 64'd0);
        check("rst_outputs", {result_sum, result_max[0], result_beats, result_err} == '0, 64'd1);
        cyc();
        RST_N = 1'b1;
        cyc();

        // Gapless burst, data = 2*i; EN_start held during REQ and part of COLLECT.
        start_burst();
        check("req_blockread", 64'(EN_blockRead), 64'd1);
        check("req_rdy", 64'(RDY_start), 64'd0);
        pulses = 0;
        for (int i = 0; i < 64; i++) begin
            EN_start     = (i < 5);
            VALID_memVal = 1'b1;
            memVal_data  = 32'(2 * i);
            if (EN_blockRead) pulses++;
            if (i == 63) check("valid_before_last", 64'(VALID_result), 64'd0);
            cyc();
        end
        EN_start     = 1'b0;
        VALID_memVal = 1'b0;
        check("blockread_pulses", 64'(pulses), 64'd1);
        check("b1_valid", 64'(VALID_result), 64'd1);
        check("b1_sum", 64'(result_sum), 64'd4032);
        check("b1_max", 64'(result_max), 64'd126);
        check("b1_beats", 64'(result_beats), 64'd64);
        check("b1_err", 64'(result_err), 64'd0);

        // Hold in DONE with stray beats and EN_start
        for (int i = 0; i < 10; i++) begin
            EN_start     = 1'b1;
            VALID_memVal = i[0];
            memVal_data  = 32'hFFFF_0000;
            cyc();
        end
        EN_start     = 1'b0;
        VALID_memVal = 1'b0;
        check("hold_sum", 64'(result_sum), 64'd4032);
        check("hold_max", 64'(result_max), 64'd126);
        check("hold_beats", 64'(result_beats), 64'd64);
        check("hold_rdy", 64'(RDY_start), 64'd0);
        check("hold_valid", 64'(VALID_result), 64'd1);
        take_result();
        check("take_rdy", 64'(RDY_start), 64'd1);
        check("take_valid", 64'(VALID_result), 64'd0);
        check("idle_hold_sum", 64'(result_sum), 64'd4032);

        // Alternating valid, all-ones data; invalid cycles carry different data
        start_burst();
        for (int i = 0; i < 64; i++) begin
            VALID_memVal = 1'b1;
            memVal_data  = 32'hFFFF_FFFF;
            cyc();
            VALID_memVal = 1'b0;
            memVal_data  = 32'h0000_DEAD;
            if (i < 63) cyc();
        end
        check("b2_valid", 64'(VALID_result), 64'd1);
        check("b2_sum", 64'(result_sum), 64'h3F_FFFF_FFC0);
        check("b2_max", 64'(result_max), 64'hFFFF_FFFF);
        check("b2_beats", 64'(result_beats), 64'd64);
        take_result();

        // Reset after 20 beats, stream keeps running afterwards
        start_burst();
        for (int i = 0; i < 20; i++) begin
            VALID_memVal = 1'b1;
            memVal_data  = 32'd7;
            cyc();
        end
        check("pre_rst_beats", 64'(result_beats), 64'd20);
        #2;
        RST_N = 1'b0;
        #1;
        check("midrst_rdy", 64'(RDY_start), 64'd1);
        check("midrst_valid", 64'(VALID_result), 64'd0);
        check("midrst_sum", 64'(result_sum), 64'd0);
        check("midrst_beats", 64'(result_beats), 64'd0);
        check("midrst_max", 64'(result_max), 64'd0);
        cyc();
        RST_N = 1'b1;
        cyc();
        cyc();
        check("post_rst_idle_beats", 64'(result_beats), 64'd0);
        check("post_rst_rdy", 64'(RDY_start), 64'd1);
        VALID_memVal = 1'b0;
        start_burst();
        for (int i = 0; i < 64; i++) begin
            VALID_memVal = 1'b1;
            memVal_data  = 32'd1;
            cyc();
        end
        VALID_memVal = 1'b0;
        check("b3_valid", 64'(VALID_result), 64'd1);
        check("b3_sum", 64'(result_sum), 64'd64);
        check("b3_max", 64'(result_max), 64'd1);
        take_result();

        // 10 beats of 5, then silence
        start_burst();
        for (int i = 0; i < 10; i++) begin
            VALID_memVal = 1'b1;
            memVal_data  = 32'd5;
            cyc();
        end
        VALID_memVal = 1'b0;
`ifdef REDUCER_TIMEOUT_EN
        for (int i = 0; i < 15; i++) cyc();
        check("to_valid_early", 64'(VALID_result), 64'd0);
        cyc();
        check("to_valid", 64'(VALID_result), 64'd1);
        check("to_err", 64'(result_err), 64'd1);
        check("to_beats", 64'(result_beats), 64'd10);
        check("to_sum", 64'(result_sum), 64'd50);
        check("to_max", 64'(result_max), 64'd5);
        take_result();
        check("to_rdy", 64'(RDY_start), 64'd1);
`else
        for (int i = 0; i < 40; i++) cyc();
        check("nto_valid", 64'(VALID_result), 64'd0);
        check("nto_err", 64'(result_err), 64'd0);
        check("nto_beats", 64'(result_beats), 64'd10);
        check("nto_sum", 64'(result_sum), 64'd50);
        RST_N = 1'b0;
        cyc();
        RST_N = 1'b1;
        cyc();
        check("nto_rdy", 64'(RDY_start), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
